// File: rtl/pwm_duty_gen.sv
// PWM compare stage: double-buffered duty register with period-boundary update,
// registered PWM output, period-start pulse and a dead-time complementary pair.
module pwm_duty_gen #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEAD  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             enable,
   input  logic [WIDTH:0]   duty_in,
   input  logic             duty_valid,
   output logic             duty_ready,
   output logic             pwm_out,
   output logic             pwm_h,
   output logic             pwm_l,
   output logic             period_start
);

   localparam int unsigned DW = WIDTH + 1;
   localparam int unsigned CW = 8;
   localparam logic [DW-1:0]    DUTY_MAX  = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
   localparam logic [CW-1:0]    DEAD_LD   = CW'(DEAD);

   logic [DW-1:0] shadow_q, shadow_d;
   logic [DW-1:0] active_q, active_d;
   logic          pending_q, pending_d;
   logic          boundary_q;
   logic          enable_q;
   logic          pwm_q, pwm_d;
   logic          pwm_h_q, pwm_h_d;
   logic          pwm_l_q, pwm_l_d;
   logic          period_start_q, period_start_d;
   logic [CW-1:0] dead_q, dead_d;
   logic          boundary;
   logic          xfer;

   assign duty_ready   = !pending_q && !reset;
   assign pwm_out      = pwm_q;
   assign pwm_h        = pwm_h_q;
   assign pwm_l        = pwm_l_q;
   assign period_start = period_start_q;

   // Duty double buffer: handshake fills shadow, period boundary promotes it.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      boundary  = (count_in == COUNT_MAX) && enable;
      xfer      = duty_valid && duty_ready;
      if (boundary && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (xfer) begin
         shadow_d  = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
         pending_d = 1'b1;
      end
   end

   // Compare, period marker and dead-time insertion; enable rise counts as an edge.
   always_comb begin
      pwm_d          = enable && ({1'b0, count_in} < active_q);
      period_start_d = boundary_q && enable;
      dead_d         = '0;
      pwm_h_d        = 1'b0;
      pwm_l_d        = 1'b0;
      if (enable) begin
         if ((pwm_d != pwm_q) || !enable_q) begin
            dead_d = DEAD_LD;
         end else if (dead_q != '0) begin
            dead_d = dead_q - CW'(1);
         end
         if (dead_d == '0) begin
            pwm_h_d = pwm_d;
            pwm_l_d = !pwm_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q       <= '0;
         active_q       <= '0;
         pending_q      <= 1'b0;
         boundary_q     <= 1'b0;
         enable_q       <= 1'b0;
         pwm_q          <= 1'b0;
         pwm_h_q        <= 1'b0;
         pwm_l_q        <= 1'b0;
         period_start_q <= 1'b0;
         dead_q         <= '0;
      end else begin
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         boundary_q     <= boundary;
         enable_q       <= enable;
         pwm_q          <= pwm_d;
         pwm_h_q        <= pwm_h_d;
         pwm_l_q        <= pwm_l_d;
         period_start_q <= period_start_d;
         dead_q         <= dead_d;
      end
   end

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen: three instances (DEAD=2,3,0) share stimulus; a cycle
// model feeds a scoreboard, and scenario tasks check per-period totals.
module tb_pwm_duty_gen;

   logic       clk = 1'b0;
   logic       reset, enable, duty_valid;
   logic [3:0] count_in;
   logic [4:0] duty_in;

   logic rdy2, pwm2, h2, l2, ps2;
   logic rdy3, pwm3, h3, l3, ps3;
   logic rdy0, pwm0, h0, l0, ps0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pwm_duty_gen #(.WIDTH(4), .DEAD(2)) u_dut2 (
      .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
      .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(rdy2),
      .pwm_out(pwm2), .pwm_h(h2), .pwm_l(l2), .period_start(ps2));

   pwm_duty_gen #(.WIDTH(4), .DEAD(3)) u_dut3 (
      .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
      .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(rdy3),
      .pwm_out(pwm3), .pwm_h(h3), .pwm_l(l3), .period_start(ps3));

   pwm_duty_gen #(.WIDTH(4), .DEAD(0)) u_dut0 (
      .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
      .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(rdy0),
      .pwm_out(pwm0), .pwm_h(h0), .pwm_l(l0), .period_start(ps0));

   typedef struct {
      logic pwm, ps, rdy, h2, l2, h3, l3, h0, l0;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic [4:0] m_active, m_shadow;
   logic       m_pend, m_bnd, m_b, m_x, m_pwm, m_ps, m_en;
   logic [3:0] hp = '0;
   logic [3:0] he = '0;
   exp_t       e, a;
   logic [11:0] exp_v, got_v;

   // Dead-time outputs follow pwm only once pwm and enable held steady for d+1 outputs.
   function automatic logic held(input int d, input logic v);
      for (int k = 0; k <= d; k++)
         if (!he[k] || hp[k] !== v) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_active = '0; m_shadow = '0; m_pend = 1'b0; m_bnd = 1'b0;
         m_pwm = 1'b0; m_ps = 1'b0; m_en = 1'b0;
      end else begin
         m_b   = (count_in == 4'd15) && enable;
         m_x   = duty_valid && !m_pend;
         m_pwm = enable && ({1'b0, count_in} < m_active);
         m_ps  = m_bnd && enable;
         m_en  = enable;
         if (m_b && m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
         end
         if (m_x) begin
            m_shadow = (duty_in > 5'd16) ? 5'd16 : duty_in;
            m_pend   = 1'b1;
         end
         m_bnd = m_b;
      end
      hp = {hp[2:0], m_pwm};
      he = {he[2:0], m_en};
      e.pwm = m_pwm;           e.ps = m_ps;             e.rdy = !m_pend && !reset;
      e.h2  = held(2, 1'b1);   e.l2 = held(2, 1'b0);
      e.h3  = held(3, 1'b1);   e.l3 = held(3, 1'b0);
      e.h0  = held(0, 1'b1);   e.l0 = held(0, 1'b0);
      sb.push_back(e);
      #1;
      a = sb.pop_front();
      exp_v = {a.pwm, a.ps, a.rdy, a.h2, a.l2, a.h3, a.l3, a.h0, a.l0, a.pwm, a.pwm, a.ps};
      got_v = {pwm2, ps2, rdy2, h2, l2, h3, l3, h0, l0, pwm3, pwm0, ps3};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL cycle_model t=%0t cnt=%0d: got %b want %b", $time, count_in, got_v, exp_v);
      end
      checks++;
      if ((h2 && l2) || (h3 && l3) || (h0 && l0)) begin
         errors++;
         $display("FAIL overlap t=%0t: h/l pairs got %b%b %b%b %b%b want never both 1",
                  $time, h2, l2, h3, l3, h0, l0);
      end
   end

   int  n_pwm, n_ps, n_ps0, n_rdy_lo, n_h2, n_l2, n_h3, n_l3, n_h0, n_l0;
   logic acc;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         count_in = count_in + 4'd1;
      end
   endtask

   task automatic goto_count(input logic [3:0] v);
      for (int i = 0; i < 16 && count_in != v; i++) cyc(1);
   endtask

   // One full period starting at count 0; optional write at req_at, optional held follow-up.
   task automatic run_period(input int req_at, input logic [4:0] req, input int hold_next);
      int nxt;
      nxt = hold_next;
      n_pwm = 0; n_ps = 0; n_ps0 = 0; n_rdy_lo = 0;
      n_h2 = 0; n_l2 = 0; n_h3 = 0; n_l3 = 0; n_h0 = 0; n_l0 = 0;
      goto_count(4'd0);
      for (int i = 0; i < 16; i++) begin
         if (i == req_at) begin
            duty_valid = 1'b1;
            duty_in    = req;
         end
         acc = duty_valid && rdy2;
         cyc(1);
         if (acc) begin
            duty_valid = 1'b0;
            if (nxt >= 0) begin
               duty_valid = 1'b1;
               duty_in    = 5'(nxt);
               nxt        = -1;
            end
         end
         n_pwm += int'(pwm2);
         n_h2 += int'(h2); n_l2 += int'(l2);
         n_h3 += int'(h3); n_l3 += int'(l3);
         n_h0 += int'(h0); n_l0 += int'(l0);
         if (!rdy2) n_rdy_lo++;
         if (ps2) begin
            n_ps++;
            if (i == 0 && pwm2) n_ps0++;
         end
      end
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; duty_valid = 1'b0; duty_in = '0; count_in = '0;
      cyc(3);
      checks++;
      if ({pwm2, h2, l2, ps2, pwm3, h3, l3, pwm0, h0, l0} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0", {pwm2, h2, l2, ps2, pwm3, h3, l3, pwm0, h0, l0});
      end
      checks++;
      if (rdy2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_low: got %b want 0", rdy2);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (rdy2 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_high: got %b want 1", rdy2);
      end
   endtask

   task automatic test_basic;
      run_period(7, 5'd4, -1);
      chk("basic_before_wrap_hi", n_pwm, 0);
      run_period(-1, 5'd0, -1);
      chk("basic_hi", n_pwm, 4);
      chk("basic_ps", n_ps, 1);
      chk("basic_ps_first_high", n_ps0, 1);
      run_period(-1, 5'd0, -1);
      chk("basic_hi_repeat", n_pwm, 4);
      chk("basic_ps_repeat", n_ps, 1);
   endtask

   task automatic test_extremes;
      run_period(7, 5'd0, -1);
      chk("ext_still4", n_pwm, 4);
      run_period(7, 5'd16, -1);
      chk("ext_duty0", n_pwm, 0);
      run_period(7, 5'd20, -1);
      chk("ext_duty16", n_pwm, 16);
      chk("ext_duty16_ps", n_ps, 1);
      run_period(-1, 5'd0, -1);
      chk("ext_duty20_sat", n_pwm, 16);
   endtask

   task automatic test_back_to_back;
      run_period(7, 5'd4, -1);
      run_period(-1, 5'd0, -1);
      chk("b2b_active4", n_pwm, 4);
      run_period(5, 5'd8, 12);
      chk("b2b_cur_period", n_pwm, 4);
      chk("b2b_ready_low", n_rdy_lo, 10);
      chk("b2b_12_waiting", int'(duty_valid), 1);
      run_period(-1, 5'd0, -1);
      chk("b2b_period8", n_pwm, 8);
      chk("b2b_12_taken", int'(duty_valid), 0);
      chk("b2b_ready_low2", n_rdy_lo, 15);
      run_period(-1, 5'd0, -1);
      chk("b2b_period12", n_pwm, 12);
   endtask

   task automatic test_dead_time;
      run_period(7, 5'd8, -1);
      run_period(-1, 5'd0, -1);
      chk("dt8_pwm", n_pwm, 8);
      chk("dt8_h2", n_h2, 6);
      chk("dt8_l2", n_l2, 6);
      chk("dt8_h3", n_h3, 5);
      chk("dt8_l3", n_l3, 5);
      chk("dt8_h0", n_h0, 8);
      chk("dt8_l0", n_l0, 8);
      run_period(7, 5'd1, -1);
      run_period(-1, 5'd0, -1);
      chk("dt1_pwm", n_pwm, 1);
      chk("dt1_h3", n_h3, 0);
      chk("dt1_l3", n_l3, 12);
      chk("dt1_h2", n_h2, 0);
      chk("dt1_l2", n_l2, 13);
      chk("dt1_h0", n_h0, 1);
      chk("dt1_l0", n_l0, 15);
   endtask

   task automatic test_enable;
      int n_any;
      run_period(7, 5'd8, -1);
      run_period(-1, 5'd0, -1);
      chk("en_active8", n_pwm, 8);
      goto_count(4'd3);
      enable = 1'b0; duty_valid = 1'b1; duty_in = 5'd4;
      n_any = 0;
      for (int i = 0; i < 23; i++) begin
         acc = duty_valid && rdy2;
         cyc(1);
         if (acc) duty_valid = 1'b0;
         if (pwm2 | h2 | l2 | ps2 | pwm3 | h3 | l3 | pwm0 | h0 | l0) n_any++;
      end
      chk("en_off_outputs", n_any, 0);
      chk("en_off_accepted", int'(duty_valid), 0);
      chk("en_off_ready", int'(rdy2), 0);
      enable = 1'b1;
      cyc(1);
      chk("en_rise_l2_0", int'(l2), 0);
      chk("en_rise_l0_0", int'(l0), 1);
      cyc(1);
      chk("en_rise_l2_1", int'(l2), 0);
      cyc(1);
      chk("en_rise_l2_2", int'(l2), 1);
      run_period(-1, 5'd0, -1);
      chk("en_new_duty", n_pwm, 4);
      chk("en_ps", n_ps, 1);
   endtask

   task automatic test_reset_mid;
      run_period(7, 5'd8, -1);
      run_period(-1, 5'd0, -1);
      chk("rm_active8", n_pwm, 8);
      goto_count(4'd3);
      duty_valid = 1'b1; duty_in = 5'd5;
      cyc(1);
      duty_valid = 1'b0;
      chk("rm_pending", int'(rdy2), 0);
      goto_count(4'd9);
      reset = 1'b1;
      cyc(1);
      checks++;
      if ({pwm2, h2, l2, ps2, pwm3, h3, l3, pwm0, h0, l0} !== 10'b0) begin
         errors++;
         $display("FAIL rm_outputs: got %b want 0", {pwm2, h2, l2, ps2, pwm3, h3, l3, pwm0, h0, l0});
      end
      reset = 1'b0;
      #1;
      chk("rm_ready", int'(rdy2), 1);
      run_period(-1, 5'd0, -1);
      chk("rm_hi_zero", n_pwm, 0);
      run_period(7, 5'd3, -1);
      chk("rm_hi_zero2", n_pwm, 0);
      run_period(-1, 5'd0, -1);
      chk("rm_new_duty", n_pwm, 3);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_extremes;
      test_back_to_back;
      test_dead_time;
      test_enable;
      test_reset_mid;
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_duty_gen.md
Name: pwm_duty_gen

Overview:
- Downstream stage of the PWM free-running up-counter.
- Consumes the counter value and compares it against a double-buffered duty register to produce the PWM waveform.
- Also produces a complementary high/low pair with programmable dead time for half-bridge drive.
- Duty updates arrive over a valid/ready handshake and take effect only at period boundaries, so no glitched or truncated periods occur.

Parameters:
- WIDTH, 4: counter width; period = 2^WIDTH clocks.
- DEAD, 2: dead-time length in clocks, range 0..255; 0 disables dead-time insertion.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- count_in  input  WIDTH  current value of the upstream counter; increments by 1 per clock and wraps 2^WIDTH-1 -> 0
- enable  input  1  output enable; low forces all outputs low
- duty_in  input  WIDTH+1  requested duty, in clocks high per period (0..2^WIDTH)
- duty_valid  input  1  duty_in is valid this cycle
- duty_ready  output  1  block can accept duty_in this cycle
- pwm_out  output  1  registered PWM, high while count < active duty
- pwm_h  output  1  high-side drive, with dead time
- pwm_l  output  1  low-side drive, with dead time
- period_start  output  1  one-cycle pulse aligned with the pwm_out sample for count 0

Behaviour:
- Reset state: active_duty=0, shadow_duty=0, pending=0, pwm_out=0, pwm_h=0, pwm_l=0, period_start=0, dead counter=0.
- duty_ready = !pending && !reset. Reset mid-operation discards any pending or active duty immediately.
- Handshake acceptance:
  - A transfer occurs when duty_valid && duty_ready.
  - On transfer, shadow_duty <= min(duty_in, 2^WIDTH) (saturating), and pending <= 1.
- Boundary event:
  - Occurs when count_in == 2^WIDTH-1 && enable.
  - If pending, active_duty <= shadow_duty and pending <= 0.
  - The new duty therefore governs the period starting at count 0.
- Simultaneous transfer and boundary (only possible when pending=0): the value goes to shadow and applies at the following boundary, not the current one.
- Compare and latency:
  - raw = (count_in < active_duty), with the compare done in WIDTH+1 bits.
  - pwm_out <= raw && enable, giving 1-cycle latency from count_in to pwm_out.
  - Duty 0 gives a constant low output; duty 2^WIDTH gives a constant high output.
- period_start <= boundary event. It is high in the same cycle pwm_out reflects count 0.
- Dead time with DEAD > 0, driven from pwm_out:
  - A change of pwm_out drives both outputs low immediately (same cycle as pwm_out changes) and loads the dead counter with DEAD.
  - The counter decrements each clock.
  - When it reaches 0, pwm_h = pwm_out and pwm_l = !pwm_out.
  - If pwm_out changes again before expiry, both outputs stay low and the counter reloads.
  - pwm_h and pwm_l are never high together.
- Dead time with DEAD = 0: pwm_h = pwm_out, pwm_l = !pwm_out && enable.
- enable low:
  - pwm_out, pwm_h, pwm_l and period_start are 0, and the dead counter clears.
  - No boundary events occur, so active_duty holds.
  - The handshake still accepts into shadow (one value, then ready drops).
- enable rising: the first boundary event loads any pending shadow. Until then the stale active_duty is used. After the transition, pwm_h/pwm_l observe the full dead time.

Test Plan:
- Reset, enable=1, write duty 4 at count 7 -> applied at next wrap; pwm_out high exactly 4 clocks (counts 0-3) of each 16; period_start pulses once per 16 clocks, coincident with the first high clock.
- Duty 0, 16, then 20 on successive periods -> pwm_out constant 0 for one period, then constant 1 for two periods (20 saturates to 16).
- Active duty 4; write duty 8 at count 5, then hold duty_valid with 12 -> duty_ready=0 after the first transfer; the current period stays 4 high; the next period is 8 high; 12 accepted after the wrap and applied one period later.
- DEAD=2, duty 8 -> per period: pwm_h high 6 clocks, pwm_l high 6 clocks, both low 2 clocks after each pwm_out edge; never both high.
- DEAD=3, duty 1 -> pwm_out high 1 clock; pwm_h never asserts; pwm_l low 3 clocks after each pwm_out edge (both low for 4 consecutive clocks), then high 12 clocks.
- Assert reset at count 9 with pending=1 and active duty 8 -> next cycle all outputs 0, duty_ready=1 after reset releases, pending cleared; pwm_out stays 0 until a new duty is written and a wrap occurs.
